// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: single-clock FIFO with fill count, almost-full/almost-empty
// thresholds, synchronous flush, standard or first-word-fall-through read
// mode, and write-while-full pass-through when a read is accepted alongside.
//
// Ports:
//   clk_i          rising-edge clock for all state
//   rst_i          synchronous active-high reset (clears memory and rdata_o)
//   flush_i        synchronous empty request (memory and rdata_o retained)
//   wr_en_i        write request, wdata_i is the word
//   rd_en_i        read request (pop of the presented word in FWFT mode)
//   rdata_o        read data
//   rvalid_o       standard: one-cycle pulse after an accepted read;
//                  FWFT: a word is presented
//   full_o/empty_o occupancy == DEPTH / == 0
//   almost_full_o  count_o >= AF_LEVEL
//   almost_empty_o count_o <= AE_LEVEL
//   count_o        occupancy 0..DEPTH
//   overflow_o     one-cycle pulse: write requested but rejected
//   underflow_o    one-cycle pulse: read requested while empty
module sync_fifo_ext #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     rvalid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_P    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_P    = PW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PW-1:0]    count;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             empty, full;
  logic             rd_ok, wr_ok;

  // Pointer difference modulo 2^PW gives occupancy directly; the wrap bit
  // distinguishes full from empty.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_P);

  // A read frees a slot in the same edge, so a write at full is still
  // accepted when paired with an accepted read.
  assign rd_ok = rd_en_i && !empty;
  assign wr_ok = wr_en_i && (!full || rd_ok);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_idx] = wdata_i;
        wr_ptr_d      = wr_ptr_q + PW'(1);
      end
      if (rd_ok) begin
        rdata_d  = mem_q[rd_idx];
        rvalid_d = 1'b1;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      overflow_d  = wr_en_i && !wr_ok;
      underflow_d = rd_en_i && empty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // FWFT presents the head entry straight from storage; standard mode
  // serves the word captured at the accepting edge.
  assign rdata_o        = (FWFT != 0) ? mem_q[rd_idx] : rdata_q;
  assign rvalid_o       = (FWFT != 0) ? !empty : rvalid_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count >= AF_P);
  assign almost_empty_o = (count <= AE_P);
  assign count_o        = count;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised single-clock FIFO: next generation of the team's synchronous FIFO. Adds a fill-level count, programmable almost-full/almost-empty thresholds, and a synchronous flush. It also adds selectable standard or first-word-fall-through (FWFT) read mode, and a read-while-full pass-through. It sits between same-clock producer/consumer blocks wherever buffering with early back-pressure is needed.

## Interface
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥4.
- AF_LEVEL, DEPTH-2, almost_full_o asserts when count_o ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty_o asserts when count_o ≤ AE_LEVEL (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- clk_i  in  1  single clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous empty-the-FIFO request.
- wr_en_i  in  1  write request.
- wdata_i  in  WIDTH  write data.
- rd_en_i  in  1  read request (pop in FWFT).
- rdata_o  out  WIDTH  read data.
- rvalid_o  out  1  rdata_o holds a valid word (meaning per mode).
- full_o, empty_o  out  1 each  count_o == DEPTH / count_o == 0.
- almost_full_o, almost_empty_o  out  1 each  threshold flags.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o, underflow_o  out  1 each  one-cycle error pulses.

## Operation
- Storage: DEPTH×WIDTH register array. wr_ptr/rd_ptr each $clog2(DEPTH)+1 bits; MSB is the wrap bit. Pointers wrap naturally from DEPTH-1 to 0 and toggle the MSB.
- count_o = wr_ptr − rd_ptr (modulo width). All status flags are decoded from registered pointers only; there is no combinational path from any input to any flag.
- Acceptance at each edge, using pre-edge state:
  - Read accepted = rd_en_i & !empty_o.
  - Write accepted = wr_en_i & (!full_o | read accepted). Write while full is therefore accepted when a read is accepted in the same cycle; count is unchanged.
  - Write while empty plus read: write accepted, read rejected. There is no bypass in either mode.
- overflow_o is registered to 1 for one cycle when wr_en_i is set and the write is rejected.
- underflow_o is registered to 1 for one cycle when rd_en_i is set and empty_o is high. Otherwise both are 0.
- Standard mode (FWFT=0):
  - On an accepted read, rdata_o ← mem[rd_ptr] at that edge, and rvalid_o = 1 for the next cycle only.
  - rdata_o holds its last value otherwise.
- FWFT mode:
  - rdata_o = mem[rd_ptr] continuously.
  - rvalid_o = !empty_o.
  - rd_en_i while rvalid_o consumes the presented word; the next word is presented in the following cycle.
- Flush: pointers → 0, rvalid_o → 0, error pulses → 0. Memory contents and (standard mode) rdata_o are retained. Flush overrides wr_en_i/rd_en_i in the same cycle: no write, no read, no error pulse.
- Reset: same as flush, plus rdata_o → 0 and memory cleared to 0. rst_i has priority over flush_i.

## Timing
- Reset values: rdata_o=0, rvalid_o=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0.
- Write → flags: count_o, empty_o and the other flags update in the cycle after the accepting edge.
- Write → read data, FWFT: a word written into an empty FIFO appears on rdata_o, with rvalid_o=1, one cycle after the write edge.
- Write → read data, standard: the earliest rdata_o is 1 cycle after the first rd_en_i edge that follows the write edge.
- Read latency, standard mode: 1 cycle from the accepting edge to rdata_o/rvalid_o.
- Sustained throughput: one write and one read per cycle at any occupancy, including full (pass-through) and wrap-around.
- Reset or flush mid-stream: takes effect at that edge. In-flight words are discarded, and the next cycle shows the reset flag values.

## Test plan
- Fill: reset, then 16 writes of 0x01..0x10 (DEPTH=16, AF=14, AE=2). almost_empty_o drops after the 3rd write, almost_full_o rises after the 14th, full_o=1 and count_o=16 after the 16th. A 17th write gives overflow_o=1 for one cycle, with count unchanged.
- Drain, standard mode: 16 reads return 0x01..0x10 in order, each one cycle after its edge with rvalid_o pulsing. A 17th read gives underflow_o=1 and rvalid_o=0.
- Full pass-through: at full, assert wr_en_i=rd_en_i=1 with data 0xAA. The read returns the oldest word, count stays 16, no overflow, and 0xAA is later read out in last position.
- Empty simultaneous access: FWFT=1 and empty, wr 0x5C + rd_en_i together. underflow_o=1, and 0x5C appears on rdata_o with rvalid_o=1 the next cycle.
- Wrap: stream 40 words with interleaved random rd/wr. Read order matches a reference queue, and count_o matches queue size every cycle.
- Flush/reset mid-operation: with 7 words held, pulse flush_i with wr_en_i=1. Next cycle count_o=0, empty_o=1, no overflow, and the written word is never read. Repeat with rst_i: same flags, and rdata_o=0.
